arm7tdmi_tap_ctrl: RTL and testbench

- JTAG TAP controller for the ARM7TDMI debug/test port.
- Contains the 16-state IEEE 1149.1 state machine, a 4-bit instruction register, the SCAN_N chain-number register, and the BYPASS and IDCODE data registers.
- Generates the capture/shift/update strobes and the chain number that drive the scan chain selector.
- Muxes the serial return path onto the off-chip TDO pin.

---
 rtl/arm7tdmi_tap_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_arm7tdmi_tap_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_tap_ctrl.sv
// ARM7TDMI JTAG TAP controller: 1149.1 state machine, IR, SCAN_N, BYPASS and optional IDCODE.
// Define ARM_TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module arm7tdmi_tap_ctrl #(
   parameter logic [31:0] IDCODE_VALUE = 32'h3F0F0F0F,
   parameter int          SCAN_N_WIDTH = 4
) (
   input  logic                    tck,
   input  logic                    trst_n,
   input  logic                    tms,
   input  logic                    tdi,
   output logic                    tdo,
   output logic                    tdo_en,
   input  logic                    chain_tdo,
   output logic                    capture_dr,
   output logic                    shift_dr,
   output logic                    update_dr,
   output logic                    capture_ir,
   output logic                    shift_ir,
   output logic                    update_ir,
   output logic                    tlr_state,
   output logic                    rti_state,
   output logic                    scan_n_update,
   output logic [SCAN_N_WIDTH-1:0] scan_chain_id,
   output logic                    chain_access,
   output logic                    restart_req,
   output logic [3:0]              ir_value
);

   localparam logic [3:0] ST_EX2DR = 4'h0;
   localparam logic [3:0] ST_EX1DR = 4'h1;
   localparam logic [3:0] ST_SHDR  = 4'h2;
   localparam logic [3:0] ST_PADR  = 4'h3;
   localparam logic [3:0] ST_SELIR = 4'h4;
   localparam logic [3:0] ST_UPDR  = 4'h5;
   localparam logic [3:0] ST_CAPDR = 4'h6;
   localparam logic [3:0] ST_SELDR = 4'h7;
   localparam logic [3:0] ST_EX2IR = 4'h8;
   localparam logic [3:0] ST_EX1IR = 4'h9;
   localparam logic [3:0] ST_SHIR  = 4'hA;
   localparam logic [3:0] ST_PAIR  = 4'hB;
   localparam logic [3:0] ST_RTI   = 4'hC;
   localparam logic [3:0] ST_UPIR  = 4'hD;
   localparam logic [3:0] ST_CAPIR = 4'hE;
   localparam logic [3:0] ST_TLR   = 4'hF;

   localparam logic [3:0] IR_EXTEST  = 4'b0000;
   localparam logic [3:0] IR_SCAN_N  = 4'b0010;
   localparam logic [3:0] IR_SAMPLE  = 4'b0011;
   localparam logic [3:0] IR_RESTART = 4'b0100;
   localparam logic [3:0] IR_INTEST  = 4'b1100;
   localparam logic [3:0] IR_IDCODE  = 4'b1110;
   localparam logic [3:0] IR_BYPASS  = 4'b1111;
`ifdef ARM_TAP_IDCODE_EN
   localparam logic [3:0] IR_RESET   = IR_IDCODE;
`else
   localparam logic [3:0] IR_RESET   = IR_BYPASS;
`endif

   localparam logic [SCAN_N_WIDTH-1:0] SCAN_N_CAPTURE = {1'b1, {(SCAN_N_WIDTH-1){1'b0}}};

   logic [3:0]              state_reg, state_next;
   logic [3:0]              ir_shift_reg, ir_value_reg;
   logic [SCAN_N_WIDTH-1:0] scan_n_shift_reg, scan_chain_id_reg;
   logic                    bypass_reg;
   logic                    upd_prev_reg;
   logic                    tdo_reg, tdo_en_reg;
   logic                    sel_scan_n, sel_idcode, sel_restart;
   logic                    serial_out;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_TLR:   state_next = tms ? ST_TLR   : ST_RTI;
         ST_RTI:   state_next = tms ? ST_SELDR : ST_RTI;
         ST_SELDR: state_next = tms ? ST_SELIR : ST_CAPDR;
         ST_CAPDR: state_next = tms ? ST_EX1DR : ST_SHDR;
         ST_SHDR:  state_next = tms ? ST_EX1DR : ST_SHDR;
         ST_EX1DR: state_next = tms ? ST_UPDR  : ST_PADR;
         ST_PADR:  state_next = tms ? ST_EX2DR : ST_PADR;
         ST_EX2DR: state_next = tms ? ST_UPDR  : ST_SHDR;
         ST_UPDR:  state_next = tms ? ST_SELDR : ST_RTI;
         ST_SELIR: state_next = tms ? ST_TLR   : ST_CAPIR;
         ST_CAPIR: state_next = tms ? ST_EX1IR : ST_SHIR;
         ST_SHIR:  state_next = tms ? ST_EX1IR : ST_SHIR;
         ST_EX1IR: state_next = tms ? ST_UPIR  : ST_PAIR;
         ST_PAIR:  state_next = tms ? ST_EX2IR : ST_PAIR;
         ST_EX2IR: state_next = tms ? ST_UPIR  : ST_SHIR;
         ST_UPIR:  state_next = tms ? ST_SELDR : ST_RTI;
         default:  state_next = ST_TLR;
      endcase
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) state_reg <= ST_TLR;
      else         state_reg <= state_next;
   end

   assign tlr_state  = (state_reg == ST_TLR);
   assign rti_state  = (state_reg == ST_RTI);
   assign capture_dr = (state_reg == ST_CAPDR);
   assign shift_dr   = (state_reg == ST_SHDR);
   assign update_dr  = (state_reg == ST_UPDR);
   assign capture_ir = (state_reg == ST_CAPIR);
   assign shift_ir   = (state_reg == ST_SHIR);
   assign update_ir  = (state_reg == ST_UPIR);

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ir_shift_reg <= 4'b0001;
         ir_value_reg <= IR_RESET;
      end else begin
         if (tlr_state)      ir_value_reg <= IR_RESET;
         else if (update_ir) ir_value_reg <= ir_shift_reg;
         if (capture_ir)     ir_shift_reg <= 4'b0001;
         else if (shift_ir)  ir_shift_reg <= {tdi, ir_shift_reg[3:1]};
      end
   end

   // Unlisted opcodes (and IDCODE when the register is absent) fall through to BYPASS.
   assign sel_scan_n   = (ir_value_reg == IR_SCAN_N);
   assign sel_restart  = (ir_value_reg == IR_RESTART);
   assign chain_access = (ir_value_reg == IR_EXTEST) || (ir_value_reg == IR_SAMPLE) ||
                         (ir_value_reg == IR_INTEST);
`ifdef ARM_TAP_IDCODE_EN
   assign sel_idcode   = (ir_value_reg == IR_IDCODE);
`else
   assign sel_idcode   = 1'b0;
`endif

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         scan_n_shift_reg  <= SCAN_N_CAPTURE;
         scan_chain_id_reg <= '0;
         bypass_reg        <= 1'b0;
         upd_prev_reg      <= 1'b0;
      end else begin
         if (capture_dr && sel_scan_n)    scan_n_shift_reg <= SCAN_N_CAPTURE;
         else if (shift_dr && sel_scan_n) scan_n_shift_reg <= {tdi, scan_n_shift_reg[SCAN_N_WIDTH-1:1]};
         if (update_dr && sel_scan_n)     scan_chain_id_reg <= scan_n_shift_reg;
         if (capture_dr)    bypass_reg <= 1'b0;
         else if (shift_dr) bypass_reg <= tdi;
         upd_prev_reg <= update_ir || update_dr;
      end
   end

`ifdef ARM_TAP_IDCODE_EN
   logic [31:0] idcode_reg;

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n)                     idcode_reg <= IDCODE_VALUE;
      else if (capture_dr && sel_idcode) idcode_reg <= IDCODE_VALUE;
      else if (shift_dr && sel_idcode)   idcode_reg <= {tdi, idcode_reg[31:1]};
   end
`endif

   always_comb begin
      serial_out = bypass_reg;
      if (shift_ir)          serial_out = ir_shift_reg[0];
      else if (chain_access) serial_out = chain_tdo;
      else if (sel_scan_n)   serial_out = scan_n_shift_reg[0];
`ifdef ARM_TAP_IDCODE_EN
      else if (sel_idcode)   serial_out = idcode_reg[0];
`endif
   end

   // Falling-edge launch gives the receiver a full half-cycle of setup before the next posedge.
   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tdo_reg    <= 1'b0;
         tdo_en_reg <= 1'b0;
      end else if (shift_ir || shift_dr) begin
         tdo_reg    <= serial_out;
         tdo_en_reg <= 1'b1;
      end else begin
         tdo_en_reg <= 1'b0;
      end
   end

   assign tdo           = tdo_reg;
   assign tdo_en        = tdo_en_reg;
   assign ir_value      = ir_value_reg;
   assign scan_chain_id = scan_chain_id_reg;
   assign scan_n_update = update_dr && sel_scan_n;
   assign restart_req   = rti_state && upd_prev_reg && sel_restart;

endmodule

// File: tb/tb_arm7tdmi_tap_ctrl.sv
// Self-checking bench for arm7tdmi_tap_ctrl: state-walk table plus scan sequences scored via a TDO queue.
// Expectations follow ARM_TAP_IDCODE_EN the same way the design does.
module tb_arm7tdmi_tap_ctrl;

   logic       tck, trst_n, tms, tdi, chain_tdo;
   logic       tdo, tdo_en;
   logic       capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
   logic       tlr_state, rti_state, scan_n_update, chain_access, restart_req;
   logic [3:0] scan_chain_id, ir_value;

`ifdef ARM_TAP_IDCODE_EN
   localparam logic [3:0] IR_RST = 4'b1110;
`else
   localparam logic [3:0] IR_RST = 4'b1111;
`endif
   localparam logic [31:0] IDCODE = 32'h3F0F0F0F;

   // Flag order: {tlr, rti, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir, tdo_en}
   localparam logic [8:0] F_NONE  = 9'h000;
   localparam logic [8:0] F_TLR   = 9'h100;
   localparam logic [8:0] F_RTI   = 9'h080;
   localparam logic [8:0] F_CAPDR = 9'h040;
   localparam logic [8:0] F_SHDR  = 9'h021;
   localparam logic [8:0] F_UPDR  = 9'h010;
   localparam logic [8:0] F_CAPIR = 9'h008;
   localparam logic [8:0] F_SHIR  = 9'h005;
   localparam logic [8:0] F_UPIR  = 9'h002;

   typedef struct {
      logic       tms_in;
      logic [8:0] exp_flags;
   } vec_t;

   vec_t vecs[22];
   logic exp_q[$];
   int   checks = 0;
   int   errors = 0;

   arm7tdmi_tap_ctrl dut (
      .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
      .chain_tdo(chain_tdo),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
      .tlr_state(tlr_state), .rti_state(rti_state), .scan_n_update(scan_n_update),
      .scan_chain_id(scan_chain_id), .chain_access(chain_access),
      .restart_req(restart_req), .ir_value(ir_value)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Called just after a negedge: samples the tdo launched there, drives inputs, crosses one posedge.
   task automatic step(input logic t, input logic d, output logic tdo_seen);
      tdo_seen = tdo;
      tms = t;
      tdi = d;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   task automatic step1(input logic t);
      logic dummy;
      step(t, 1'b0, dummy);
   endtask

   task automatic shift_loop(input int n, input logic [63:0] din, input string name);
      logic seen, exp;
      for (int i = 0; i < n; i++) begin
         step(i == n - 1, din[i], seen);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty at bit %0d, got %0b", name, i, seen);
         end else begin
            exp = exp_q.pop_front();
            check($sformatf("%s[%0d]", name, i), {63'd0, seen}, {63'd0, exp});
         end
      end
   endtask

   // RTI -> IR scan -> RTI; captured pattern 0001 is expected back LSB first.
   task automatic ir_scan(input logic [3:0] instr);
      step1(1'b1); step1(1'b1); step1(1'b0); step1(1'b0);
      exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      shift_loop(4, {60'd0, instr}, "ir_tdo");
      step1(1'b1);
      step1(1'b0);
      check("ir_value", {60'd0, ir_value}, {60'd0, instr});
   endtask

   // RTI -> DR scan -> stops in Update-DR; caller pushes expected tdo bits beforehand.
   task automatic dr_scan(input int n, input logic [63:0] din,
                          output logic upd_seen, output logic [3:0] id_seen);
      step1(1'b1); step1(1'b0); step1(1'b0);
      shift_loop(n, din, "dr_tdo");
      step1(1'b1);
      upd_seen = scan_n_update;
      id_seen  = scan_chain_id;
   endtask

   initial begin
      logic       upd;
      logic [3:0] id;
      logic [63:0] rnd;

      vecs[0]  = '{1'b0, F_RTI};   vecs[1]  = '{1'b1, F_NONE};
      vecs[2]  = '{1'b0, F_CAPDR}; vecs[3]  = '{1'b0, F_SHDR};
      vecs[4]  = '{1'b1, F_NONE};  vecs[5]  = '{1'b0, F_NONE};
      vecs[6]  = '{1'b1, F_NONE};  vecs[7]  = '{1'b0, F_SHDR};
      vecs[8]  = '{1'b1, F_NONE};  vecs[9]  = '{1'b1, F_UPDR};
      vecs[10] = '{1'b1, F_NONE};  vecs[11] = '{1'b1, F_NONE};
      vecs[12] = '{1'b0, F_CAPIR}; vecs[13] = '{1'b0, F_SHIR};
      vecs[14] = '{1'b1, F_NONE};  vecs[15] = '{1'b0, F_NONE};
      vecs[16] = '{1'b1, F_NONE};  vecs[17] = '{1'b1, F_UPIR};
      vecs[18] = '{1'b0, F_RTI};   vecs[19] = '{1'b1, F_NONE};
      vecs[20] = '{1'b1, F_NONE};  vecs[21] = '{1'b1, F_TLR};

      trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; chain_tdo = 1'b0;
      @(negedge tck); #1;
      check("rst_tlr", {63'd0, tlr_state}, 64'd1);
      check("rst_ir", {60'd0, ir_value}, {60'd0, IR_RST});
      check("rst_tdo", {62'd0, tdo, tdo_en}, 64'd0);
      check("rst_chain_id", {60'd0, scan_chain_id}, 64'd0);
      check("rst_pulses", {56'd0, capture_dr, shift_dr, update_dr, capture_ir,
                           shift_ir, update_ir, scan_n_update, restart_req}, 64'd0);
      trst_n = 1'b1;
      step1(1'b1); step1(1'b1); step1(1'b1);
      check("tms3_tlr", {63'd0, tlr_state}, 64'd1);
      check("tms3_ir", {60'd0, ir_value}, {60'd0, IR_RST});
      check("tms3_tdo_en", {63'd0, tdo_en}, 64'd0);
      check("tms3_chain_id", {60'd0, scan_chain_id}, 64'd0);

      // Walk every state; tdi held high so the lone IR shift leaves an unlisted opcode behind.
      for (int i = 0; i < 22; i++) begin
         logic dummy;
         step(vecs[i].tms_in, 1'b1, dummy);
         check($sformatf("walk%0d", i),
               {55'd0, tlr_state, rti_state, capture_dr, shift_dr, update_dr,
                capture_ir, shift_ir, update_ir, tdo_en},
               {55'd0, vecs[i].exp_flags});
      end

      step1(1'b0);
      ir_scan(4'b0010);
      check("scan_n_access", {63'd0, chain_access}, 64'd0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      dr_scan(4, 64'h1, upd, id);
      check("scan_n_upd_pulse", {63'd0, upd}, 64'd1);
      check("scan_n_id_stable", {60'd0, id}, 64'd0);
      step1(1'b0);
      check("scan_n_upd_end", {63'd0, scan_n_update}, 64'd0);
      check("scan_n_id_new", {60'd0, scan_chain_id}, 64'd1);

      ir_scan(4'b1110);
      rnd = {32'd0, $urandom};
`ifdef ARM_TAP_IDCODE_EN
      for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
      dr_scan(32, rnd, upd, id);
`else
      exp_q.push_back(1'b0); exp_q.push_back(rnd[0]); exp_q.push_back(rnd[1]);
      dr_scan(3, rnd, upd, id);
`endif
      check("idcode_no_upd", {63'd0, upd}, 64'd0);
      step1(1'b0);

      ir_scan(4'b1111);
      check("bypass_access", {63'd0, chain_access}, 64'd0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      dr_scan(3, 64'h5, upd, id);
      step1(1'b0);
      ir_scan(4'b0101);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      dr_scan(3, 64'h3, upd, id);
      step1(1'b0);
      check("unk_no_restart", {63'd0, restart_req}, 64'd0);

      ir_scan(4'b0100);
      check("restart_ir_pulse", {63'd0, restart_req}, 64'd1);
      step1(1'b0);
      check("restart_ir_end", {63'd0, restart_req}, 64'd0);
      exp_q.push_back(1'b0);
      dr_scan(1, 64'h0, upd, id);
      step1(1'b0);
      check("restart_dr_pulse", {63'd0, restart_req}, 64'd1);

      ir_scan(4'b0000);
      check("extest_access", {63'd0, chain_access}, 64'd1);
      chain_tdo = 1'b1;
      exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      dr_scan(3, 64'h0, upd, id);
      step1(1'b0);
      chain_tdo = 1'b0;
      ir_scan(4'b0011);
      check("sample_access", {63'd0, chain_access}, 64'd1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      dr_scan(3, 64'h7, upd, id);
      step1(1'b0);
      ir_scan(4'b1100);
      check("intest_access", {63'd0, chain_access}, 64'd1);

      // Five tms=1 from Shift-DR must land in TLR, and not a cycle earlier.
      step1(1'b1); step1(1'b0); step1(1'b0);
      check("sh_dr_entry", {63'd0, shift_dr}, 64'd1);
      for (int i = 0; i < 4; i++) step1(1'b1);
      check("tms4_not_tlr", {63'd0, tlr_state}, 64'd0);
      step1(1'b1);
      check("tms5_tlr", {63'd0, tlr_state}, 64'd1);
      step1(1'b1);
      check("tlr_ir_reload", {60'd0, ir_value}, {60'd0, IR_RST});

      step1(1'b0);
      ir_scan(4'b0010);
      exp_q.push_back(1'b0); exp_q.push_back(1'b0);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      dr_scan(4, 64'h0, upd, id);
      step1(1'b0);
      check("abort_pre_id", {60'd0, scan_chain_id}, 64'd0);
      step1(1'b1); step1(1'b0); step1(1'b0);
      step(1'b0, 1'b1, upd);
      step(1'b0, 1'b1, upd);
      check("abort_in_shift", {63'd0, shift_dr}, 64'd1);
      tms = 1'b1;
      trst_n = 1'b0;
      #1;
      check("abort_tlr", {63'd0, tlr_state}, 64'd1);
      check("abort_no_pulse", {62'd0, scan_n_update, tdo_en}, 64'd0);
      check("abort_id", {60'd0, scan_chain_id}, 64'd0);
      check("abort_ir", {60'd0, ir_value}, {60'd0, IR_RST});
      #1;
      trst_n = 1'b1;
      @(negedge tck); #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("post_abort%0d", i),
               {58'd0, tlr_state, update_dr, scan_n_update, scan_chain_id[2:0]}, 64'h20);
         check($sformatf("post_abort_id%0d", i), {60'd0, scan_chain_id}, 64'd0);
         step1(1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
